// File: rtl/alu_pipe_div.sv
// Clocked ALU: latency 1 for simple ops, WIDTH+1 for DIVU/REMU (restoring divider, one op in flight).
// Backpressure: result and flags are held until out_ready; in_ready is low while dividing or while a result is stalled.
module alu_pipe_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic             imm_sel,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             parity,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             div_zero,
    output logic             invalid_op
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3,
        OP_XOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL = 4'h6, OP_SRA  = 4'h7,
        OP_SLT  = 4'h8, OP_SLTU = 4'h9, OP_NOT = 4'hA, OP_MUL  = 4'hB,
        OP_DIVU = 4'hC, OP_REMU = 4'hD
    } op_e;

    typedef struct packed {
        logic parity;
        logic zero;
        logic negative;
        logic carry;
        logic overflow;
        logic div_zero;
        logic invalid_op;
    } flags_t;

    function automatic flags_t mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v,
                                        input logic dz, input logic inv);
        flags_t f;
        f.parity     = ^r;
        f.zero       = (r == '0);
        f.negative   = r[WIDTH-1];
        f.carry      = c;
        f.overflow   = v;
        f.div_zero   = dz;
        f.invalid_op = inv;
        return f;
    endfunction

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             is_rem_q, is_rem_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    flags_t           flg_q, flg_d;

    logic [WIDTH-1:0]   opb;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     sum, dif;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v, alu_dz, alu_inv, is_div, accept;

    assign opb  = imm_sel ? imm : b;
    assign sh   = opb[SHW-1:0];
    assign sum  = {1'b0, a} + {1'b0, opb};
    assign dif  = {1'b0, a} - {1'b0, opb};
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, opb};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_dz  = 1'b0;
        alu_inv = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif[WIDTH-1:0];
                alu_c   = ~dif[WIDTH];
                alu_v   = (a[WIDTH-1] != opb[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & opb;
            OP_OR:   alu_res = a | opb;
            OP_XOR:  alu_res = a ^ opb;
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = $signed(a) >>> sh;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(opb))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < opb)};
            OP_NOT:  alu_res = ~a;
            OP_MUL: begin
                alu_res = prod[WIDTH-1:0];
                alu_v   = |prod[2*WIDTH-1:WIDTH];
            end
            // Only the divide-by-zero case resolves here; real divides go to the iterative path.
            OP_DIVU: begin
                alu_res = '1;
                alu_dz  = (opb == '0);
            end
            OP_REMU: begin
                alu_res = a;
                alu_dz  = (opb == '0);
            end
            default: alu_inv = 1'b1;
        endcase
    end

    assign is_div   = (opcode == OP_DIVU) || (opcode == OP_REMU);
    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
    logic [WIDTH:0]   trial, tdiff;
    logic             qbit;
    logic [WIDTH-1:0] rem_n, dq_n, div_res;

    assign trial   = {rem_q, dq_q[WIDTH-1]};
    assign tdiff   = trial - {1'b0, dvs_q};
    assign qbit    = ~tdiff[WIDTH];
    assign rem_n   = qbit ? tdiff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign dq_n    = {dq_q[WIDTH-2:0], qbit};
    assign div_res = is_rem_q ? rem_n : dq_n;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dq_d        = dq_q;
        dvs_d       = dvs_q;
        is_rem_d    = is_rem_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        flg_d       = flg_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_div && (opb != '0)) begin
                        state_d  = S_DIV;
                        cnt_d    = '0;
                        rem_d    = '0;
                        dq_d     = a;
                        dvs_d    = opb;
                        is_rem_d = (opcode == OP_REMU);
                    end else begin
                        res_d       = alu_res;
                        flg_d       = mk_flags(alu_res, alu_c, alu_v, alu_dz, alu_inv);
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_DIV: begin
                rem_d = rem_n;
                dq_d  = dq_n;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1)) begin
                    state_d     = S_IDLE;
                    res_d       = div_res;
                    flg_d       = mk_flags(div_res, 1'b0, 1'b0, 1'b0, 1'b0);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            is_rem_q    <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flg_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dq_q        <= dq_d;
            dvs_q       <= dvs_d;
            is_rem_q    <= is_rem_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flg_q       <= flg_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = res_q;
    assign {parity, zero, negative, carry, overflow, div_zero, invalid_op} = flg_q;

endmodule

// File: tb/tb_alu_pipe_div.sv
// Bench for alu_pipe_div: scoreboard model checked every cycle plus directed literal cases.
module tb_alu_pipe_div;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, imm_sel, out_valid, out_ready;
    logic [15:0] a, b, imm, result;
    logic [3:0]  opcode;
    logic        parity, zero, negative, carry, overflow, div_zero, invalid_op;
    logic [6:0]  flags_vec;

    logic        in_valid32, in_ready32, imm_sel32, out_valid32, out_ready32;
    logic [31:0] a32, b32, imm32, result32;
    logic [3:0]  opcode32;
    logic        par32, zer32, neg32, car32, ovf32, dz32, inv32;
    logic [6:0]  flags32;

    always #5 clk = ~clk;

    alu_pipe_div #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .imm(imm), .imm_sel(imm_sel), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .parity(parity), .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .div_zero(div_zero), .invalid_op(invalid_op)
    );

    alu_pipe_div #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .imm(imm32), .imm_sel(imm_sel32), .opcode(opcode32),
        .out_valid(out_valid32), .out_ready(out_ready32), .result(result32),
        .parity(par32), .zero(zer32), .negative(neg32), .carry(car32),
        .overflow(ovf32), .div_zero(dz32), .invalid_op(inv32)
    );

    assign flags_vec = {parity, zero, negative, carry, overflow, div_zero, invalid_op};
    assign flags32   = {par32, zer32, neg32, car32, ovf32, dz32, inv32};

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 0;
    bit rnd_en = 0;

    typedef struct {
        logic [15:0] res;
        logic [6:0]  flg;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t ne;
    bit   exp_ov;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        int ux, uy, sx, sy, s;
        longint p;
        logic c, v, dz, inv;
        logic [15:0] r;
        ux = int'(x); uy = int'(y);
        sx = int'($signed(x)); sy = int'($signed(y));
        c = 0; v = 0; dz = 0; inv = 0; r = '0; s = 0; p = 0;
        case (op)
            4'h0: begin s = ux + uy; r = 16'(s); c = (s > 65535);
                        v = (sx + sy > 32767) || (sx + sy < -32768); end
            4'h1: begin s = ux - uy; r = 16'(s); c = (ux >= uy);
                        v = (sx - sy > 32767) || (sx - sy < -32768); end
            4'h2: r = x & y;
            4'h3: r = x | y;
            4'h4: r = x ^ y;
            4'h5: r = 16'(ux << y[3:0]);
            4'h6: r = 16'(ux >> y[3:0]);
            4'h7: r = 16'(sx >>> y[3:0]);
            4'h8: r = (sx < sy) ? 16'd1 : 16'd0;
            4'h9: r = (ux < uy) ? 16'd1 : 16'd0;
            4'hA: r = ~x;
            4'hB: begin p = longint'(ux) * longint'(uy); r = 16'(p); v = (p > 65535); end
            4'hC: if (uy == 0) begin r = 16'hFFFF; dz = 1; end else r = 16'(ux / uy);
            4'hD: if (uy == 0) begin r = x; dz = 1; end else r = 16'(ux % uy);
            default: inv = 1;
        endcase
        e.res = r;
        e.flg = {^r, (r == 16'h0), r[15], c, v, dz, inv};
        e.due = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Per-cycle compare against the scoreboard, then retire / enqueue on handshakes.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_ov = (sb.size() > 0) && (cyc >= sb[0].due);
            chk("out_valid", out_valid, exp_ov);
            chk("in_ready", in_ready, (sb.size() == 0) || (exp_ov && out_ready));
            if (exp_ov && out_valid) begin
                chk("result", result, sb[0].res);
                chk("flags", flags_vec, sb[0].flg);
            end
            if (exp_ov && out_ready) void'(sb.pop_front());
            if (in_valid && in_ready) begin
                ne = model(opcode, a, imm_sel ? imm : b);
                ne.due = cyc + ((opcode >= 4'hC && opcode <= 4'hD && (imm_sel ? imm : b) != 16'h0) ? 17 : 1);
                sb.push_back(ne);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] im, input logic isel);
        bit got;
        got = 0;
        opcode = op; a = x; b = y; imm = im; imm_sel = isel; in_valid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("issue_accepted", got, 1);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (out_valid) break;
            n++;
        end
        chk("wait_out_valid", out_valid, 1);
    endtask

    task automatic lit(input string nm, input logic [15:0] er, input logic [6:0] ef,
                       input int elat, input int n);
        chk({nm, "_res"}, result, er);
        chk({nm, "_flags"}, flags_vec, ef);
        chk({nm, "_latency"}, n, elat - 1);
    endtask

    initial begin
        int n;
        logic [15:0] rb;
        rst = 1'b1; in_valid = 0; a = 0; b = 0; imm = 0; imm_sel = 0; opcode = 0; out_ready = 1'b1;
        in_valid32 = 0; a32 = 0; b32 = 0; imm32 = 0; imm_sel32 = 0; opcode32 = 0; out_ready32 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", flags_vec, 0);
        chk("reset_out_valid32", out_valid32, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", in_ready, 1);
        chk("post_reset_in_ready32", in_ready32, 1);
        @(posedge clk); #1;

        // 32-bit instance: SRA by 31 and MUL with the product fully in the upper half.
        opcode32 = 4'h7; a32 = 32'h8000_0000; imm32 = 32'h0000_001F; imm_sel32 = 1; in_valid32 = 1;
        @(posedge clk); #1;
        in_valid32 = 0;
        @(negedge clk);
        chk("w32_sra_valid", out_valid32, 1);
        chk("w32_sra_res", result32, 32'hFFFF_FFFF);
        chk("w32_sra_flags", flags32, 7'b0010000);
        @(posedge clk); #1;
        opcode32 = 4'hB; a32 = 32'h0001_0000; b32 = 32'h0001_0000; imm_sel32 = 0; in_valid32 = 1;
        @(posedge clk); #1;
        in_valid32 = 0;
        @(negedge clk);
        chk("w32_mul_valid", out_valid32, 1);
        chk("w32_mul_res", result32, 32'h0);
        chk("w32_mul_flags", flags32, 7'b0100100);
        @(posedge clk); #1;

        chk_en = 1;
        issue(4'h0, 16'h7FFF, 16'h0001, 16'h0, 0);
        wait_out(n); lit("add_ovf", 16'h8000, 7'b1010100, 1, n);
        @(posedge clk); #1;
        issue(4'hC, 16'h0064, 16'h0007, 16'h0, 0);
        wait_out(n); lit("divu", 16'h000E, 7'b1000000, 17, n);
        @(posedge clk); #1;
        issue(4'hD, 16'h0064, 16'h0000, 16'h0007, 1);
        wait_out(n); lit("remu", 16'h0002, 7'b1000000, 17, n);
        @(posedge clk); #1;
        issue(4'hC, 16'h1234, 16'h0000, 16'h0, 0);
        wait_out(n); lit("divu_by0", 16'hFFFF, 7'b0010010, 1, n);
        @(posedge clk); #1;
        issue(4'hD, 16'h1234, 16'h0000, 16'h0, 0);
        wait_out(n); lit("remu_by0", 16'h1234, 7'b1000010, 1, n);
        @(posedge clk); #1;

        // Stalled consumer: result held, next request blocked until drained.
        out_ready = 1'b0;
        issue(4'h1, 16'h0003, 16'h0005, 16'h0, 0);
        opcode = 4'h0; a = 16'h0001; b = 16'h0001; imm_sel = 0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_res", result, 16'hFFFE);
            chk("hold_carry", carry, 0);
            chk("hold_no_accept", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("after_drain_res", result, 16'h0002);
        @(posedge clk); #1;

        // Reset in the middle of a division.
        issue(4'hC, 16'hFFFF, 16'h0003, 16'h0, 0);
        repeat (7) @(posedge clk);
        #1;
        chk_en = 0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_flags", flags_vec, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid_after", out_valid, 0);
        @(posedge clk); #1;
        chk_en = 1;
        issue(4'hF, 16'h5555, 16'hAAAA, 16'h0, 0);
        wait_out(n); lit("invalid", 16'h0000, 7'b0100001, 1, n);
        @(posedge clk); #1;

        // Randomized traffic with random consumer stalls.
        rnd_en = 1;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 3))
                0:       rb = 16'h0;
                1:       rb = 16'($urandom_range(1, 20));
                default: rb = 16'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1)
                issue(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), rb, 1);
            else
                issue(4'($urandom_range(0, 15)), 16'($urandom), rb, 16'($urandom), 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        rnd_en = 0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end
endmodule
